// File: rtl/writeback_stage.sv
// Writeback stage of the 16-bit core: selects the retiring value, drives the register-file
// write port and forwarding tap, waits on variable-latency loads with a timeout, and latches HLT.
module writeback_stage #(
  parameter int DATA_W      = 16,
  parameter int REG_ADDR_W  = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_dst,
  input  logic [2:0]            in_wb_sel,
  input  logic [DATA_W-1:0]     in_alu,
  input  logic [DATA_W-1:0]     in_pc_next,
  input  logic [7:0]            in_imm8,
  input  logic [DATA_W-1:0]     in_reg_old,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  WriteReg,
  output logic [REG_ADDR_W-1:0] DstReg,
  output logic [DATA_W-1:0]     DstData,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_reg,
  output logic [DATA_W-1:0]     fwd_data,
  output logic                  halted,
  output logic                  err
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD_WAIT = 2'd1;
  localparam logic [1:0] ST_COMMIT    = 2'd2;

  localparam logic [2:0] SEL_ALU  = 3'd0;
  localparam logic [2:0] SEL_LOAD = 3'd1;
  localparam logic [2:0] SEL_LLB  = 3'd2;
  localparam logic [2:0] SEL_LHB  = 3'd3;
  localparam logic [2:0] SEL_PCS  = 3'd4;
  localparam logic [2:0] SEL_HLT  = 3'd5;

  localparam logic [7:0] TIMER_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

  logic [1:0]            state_q, state_d;
  logic [7:0]            timer_q, timer_d;
  logic [REG_ADDR_W-1:0] load_dst_q, load_dst_d;
  logic                  write_q, write_d;
  logic [REG_ADDR_W-1:0] dst_reg_q, dst_reg_d;
  logic [DATA_W-1:0]     dst_data_q, dst_data_d;
  logic                  halted_q, halted_d;
  logic                  err_q, err_d;
  logic                  accept_s;

  // Byte merges keep the untouched half of the current destination value.
  function automatic logic [DATA_W-1:0] wb_value(
    input logic [2:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] pc_next,
    input logic [7:0]        imm8,
    input logic [DATA_W-1:0] reg_old
  );
    logic [DATA_W-1:0] v;
    case (sel)
      SEL_LLB: v = {reg_old[DATA_W-1:8], imm8};
      SEL_LHB: v = {imm8, reg_old[7:0]};
      SEL_PCS: v = pc_next;
      default: v = alu;
    endcase
    return v;
  endfunction

  assign in_ready = !halted_q && ((state_q == ST_IDLE) || (state_q == ST_COMMIT));
  assign accept_s = in_valid && in_ready;

  // Next-state and write-port selection.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    load_dst_d = load_dst_q;
    write_d    = 1'b0;
    dst_reg_d  = dst_reg_q;
    dst_data_d = dst_data_q;
    halted_d   = halted_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE, ST_COMMIT: begin
        if (accept_s) begin
          case (in_wb_sel)
            SEL_LOAD: begin
              load_dst_d = in_dst;
              timer_d    = 8'd0;
              state_d    = ST_LOAD_WAIT;
            end
            SEL_HLT: begin
              halted_d = 1'b1;
              state_d  = ST_COMMIT;
            end
            SEL_ALU, SEL_LLB, SEL_LHB, SEL_PCS: begin
              state_d = ST_COMMIT;
              if (in_dst != REG_ZERO) begin
                write_d    = 1'b1;
                dst_reg_d  = in_dst;
                dst_data_d = wb_value(in_wb_sel, in_alu, in_pc_next, in_imm8, in_reg_old);
              end else begin
                write_d = 1'b0;
              end
            end
            default: state_d = ST_COMMIT;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_WAIT: begin
        // A response arriving on the final wait cycle still completes the load.
        if (mem_rvalid) begin
          state_d = ST_COMMIT;
          if (load_dst_q != REG_ZERO) begin
            write_d    = 1'b1;
            dst_reg_d  = load_dst_q;
            dst_data_d = mem_rdata;
          end else begin
            write_d = 1'b0;
          end
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= 8'd0;
      load_dst_q <= REG_ZERO;
      write_q    <= 1'b0;
      dst_reg_q  <= REG_ZERO;
      dst_data_q <= {DATA_W{1'b0}};
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      load_dst_q <= load_dst_d;
      write_q    <= write_d;
      dst_reg_q  <= dst_reg_d;
      dst_data_q <= dst_data_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
    end
  end

  assign WriteReg  = write_q;
  assign DstReg    = dst_reg_q;
  assign DstData   = dst_data_q;
  assign fwd_valid = write_q && (dst_reg_q != REG_ZERO);
  assign fwd_reg   = dst_reg_q;
  assign fwd_data  = dst_data_q;
  assign halted    = halted_q;
  assign err       = err_q;

endmodule
